// File: rtl/fft_pkg.sv
// Shared constants and types for the FFT core and its output-side blocks.
package fft_pkg;

  localparam int unsigned WIDTH_OUT = 13;
  localparam int unsigned LANES     = 16;
  localparam int unsigned N         = 512;
  localparam int unsigned BEATS     = N / LANES;
  localparam int unsigned BEAT_AW   = $clog2(BEATS);
  localparam int unsigned IDX_AW    = $clog2(N);
  localparam int unsigned LANE_AW   = $clog2(LANES);
  localparam int unsigned OVF_W     = 8;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    FILL  = 2'd1,
    DRAIN = 2'd2
  } fsm_state_t;

  typedef struct packed {
    logic signed [WIDTH_OUT-1:0] re;
    logic signed [WIDTH_OUT-1:0] im;
  } fft_sample_t;

endpackage

// File: rtl/fft_bitrev_addr.sv
// Combinational bit-reversal of a W-bit index; reusable by the FFT core and the output collector.
module fft_bitrev_addr
  import fft_pkg::*;
#(
  parameter int unsigned W = IDX_AW
) (
  input  logic [W-1:0] idx_i,
  output logic [W-1:0] rev_c
);

  always_comb begin
    rev_c = '0;
    for (int i = 0; i < int'(W); i++) begin
      rev_c[i] = idx_i[int'(W) - 1 - i];
    end
  end

endmodule

// File: rtl/fft_out_collector.sv
// Captures one N-point frame from the FFT parallel output bus and replays it as a valid/ready sample stream.
// Define FFT_OUT_BITREV_EN to read storage in bit-reversed order so bins leave in natural order.
module fft_out_collector
  import fft_pkg::*;
#(
  parameter int unsigned WIDTH = WIDTH_OUT,
  parameter int unsigned LANES = fft_pkg::LANES,
  parameter int unsigned N     = fft_pkg::N
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic                          do_en,
  input  logic [LANES-1:0][WIDTH-1:0]   do_re,
  input  logic [LANES-1:0][WIDTH-1:0]   do_im,
  output logic                          m_valid,
  input  logic                          m_ready,
  output logic signed [WIDTH-1:0]       m_re,
  output logic signed [WIDTH-1:0]       m_im,
  output logic [$clog2(N)-1:0]          m_idx,
  output logic                          m_last,
  output logic                          busy,
  output logic [OVF_W-1:0]              ovf_cnt
);

  localparam int unsigned NUM_BEATS = N / LANES;
  localparam int unsigned BEAT_W    = $clog2(NUM_BEATS);
  localparam int unsigned IDX_W     = $clog2(N);
  localparam int unsigned LANE_W    = $clog2(LANES);

  fsm_state_t              state_q, state_d;
  logic [BEAT_W-1:0]       wcnt_q, wcnt_d;
  logic [IDX_W-1:0]        rcnt_q, rcnt_d;
  logic                    m_valid_q, m_valid_d;
  logic                    m_last_q, m_last_d;
  logic                    busy_q, busy_d;
  logic [WIDTH-1:0]        m_re_q, m_re_d;
  logic [WIDTH-1:0]        m_im_q, m_im_d;
  logic [OVF_W-1:0]        ovf_q, ovf_d;

  logic                    wr_en_c;
  logic [IDX_W-1:0]        rd_k_c;
  logic [IDX_W-1:0]        rd_p_c;
  logic [WIDTH-1:0]        rd_re_c;
  logic [WIDTH-1:0]        rd_im_c;

  logic [LANES-1:0][WIDTH-1:0] re_mem_q [NUM_BEATS];
  logic [LANES-1:0][WIDTH-1:0] im_mem_q [NUM_BEATS];

  // Index of the sample the output registers load at the next edge: 0 on entry to DRAIN, else k+1.
  assign rd_k_c = (state_q == DRAIN) ? IDX_W'(rcnt_q + IDX_W'(1)) : '0;

`ifdef FFT_OUT_BITREV_EN
  fft_bitrev_addr #(
    .W (IDX_W)
  ) u_bitrev (
    .idx_i (rd_k_c),
    .rev_c (rd_p_c)
  );
`else
  assign rd_p_c = rd_k_c;
`endif

  assign rd_re_c = re_mem_q[rd_p_c[IDX_W-1:LANE_W]][rd_p_c[LANE_W-1:0]];
  assign rd_im_c = im_mem_q[rd_p_c[IDX_W-1:LANE_W]][rd_p_c[LANE_W-1:0]];

  // Frame buffer: no reset, contents are only read after a complete frame has been written.
  always_ff @(posedge clk) begin
    if (wr_en_c) begin
      re_mem_q[wcnt_q] <= do_re;
      im_mem_q[wcnt_q] <= do_im;
    end
  end

  always_comb begin
    state_d   = state_q;
    wcnt_d    = wcnt_q;
    rcnt_d    = rcnt_q;
    m_valid_d = m_valid_q;
    m_last_d  = m_last_q;
    m_re_d    = m_re_q;
    m_im_d    = m_im_q;
    ovf_d     = ovf_q;
    wr_en_c   = 1'b0;

    unique case (state_q)
      IDLE: begin
        if (do_en) begin
          wr_en_c = 1'b1;
          wcnt_d  = BEAT_W'(1);
          state_d = FILL;
        end
      end

      FILL: begin
        if (do_en) begin
          wr_en_c = 1'b1;
          wcnt_d  = wcnt_q + BEAT_W'(1);
          // Last beat: sample 0 is already stored, so the output can be presented next cycle.
          if (wcnt_q == BEAT_W'(NUM_BEATS - 1)) begin
            state_d   = DRAIN;
            rcnt_d    = '0;
            m_valid_d = 1'b1;
            m_re_d    = rd_re_c;
            m_im_d    = rd_im_c;
            m_last_d  = (rd_k_c == IDX_W'(N - 1));
          end
        end
      end

      DRAIN: begin
        if (do_en && (ovf_q != '1)) begin
          ovf_d = ovf_q + OVF_W'(1);
        end
        if (m_valid_q && m_ready) begin
          if (m_last_q) begin
            state_d   = IDLE;
            m_valid_d = 1'b0;
            m_last_d  = 1'b0;
            rcnt_d    = '0;
          end else begin
            rcnt_d    = rd_k_c;
            m_re_d    = rd_re_c;
            m_im_d    = rd_im_c;
            m_last_d  = (rd_k_c == IDX_W'(N - 1));
          end
        end
      end

      default: begin
        state_d = IDLE;
      end
    endcase

    busy_d = (state_d != IDLE);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= IDLE;
      wcnt_q    <= '0;
      rcnt_q    <= '0;
      m_valid_q <= 1'b0;
      m_last_q  <= 1'b0;
      busy_q    <= 1'b0;
      m_re_q    <= '0;
      m_im_q    <= '0;
      ovf_q     <= '0;
    end else begin
      state_q   <= state_d;
      wcnt_q    <= wcnt_d;
      rcnt_q    <= rcnt_d;
      m_valid_q <= m_valid_d;
      m_last_q  <= m_last_d;
      busy_q    <= busy_d;
      m_re_q    <= m_re_d;
      m_im_q    <= m_im_d;
      ovf_q     <= ovf_d;
    end
  end

  assign m_valid = m_valid_q;
  assign m_last  = m_last_q;
  assign m_idx   = rcnt_q;
  assign m_re    = m_re_q;
  assign m_im    = m_im_q;
  assign busy    = busy_q;
  assign ovf_cnt = ovf_q;

endmodule

// File: tb/tb_fft_out_collector.sv
// Randomized bench for fft_out_collector against a frame-level reference model.
`timescale 1ns/1ps
module tb_fft_out_collector;
  import fft_pkg::*;

  localparam int unsigned W  = WIDTH_OUT;
  localparam int unsigned AW = IDX_AW;

`ifdef FFT_OUT_BITREV_EN
  localparam int unsigned RAMP_K1 = 256;
  localparam int unsigned RAMP_K3 = 384;
`else
  localparam int unsigned RAMP_K1 = 1;
  localparam int unsigned RAMP_K3 = 3;
`endif

  logic                      clk = 1'b0;
  logic                      rst;
  logic                      do_en;
  logic [LANES-1:0][W-1:0]   do_re;
  logic [LANES-1:0][W-1:0]   do_im;
  logic                      m_valid;
  logic                      m_ready;
  logic signed [W-1:0]       m_re;
  logic signed [W-1:0]       m_im;
  logic [AW-1:0]             m_idx;
  logic                      m_last;
  logic                      busy;
  logic [OVF_W-1:0]          ovf_cnt;

  always #5 clk = ~clk;

  fft_out_collector dut (
    .clk     (clk),
    .rst     (rst),
    .do_en   (do_en),
    .do_re   (do_re),
    .do_im   (do_im),
    .m_valid (m_valid),
    .m_ready (m_ready),
    .m_re    (m_re),
    .m_im    (m_im),
    .m_idx   (m_idx),
    .m_last  (m_last),
    .busy    (busy),
    .ovf_cnt (ovf_cnt)
  );

  // Reference model: captured frame plus where we are in the replay.
  logic [W-1:0] mdl_re [N];
  logic [W-1:0] mdl_im [N];
  int unsigned  cap;
  int unsigned  exp_k;
  bit           drain;
  int unsigned  ovf_exp;
  int unsigned  rdy_mode;
  int unsigned  errors;
  int unsigned  checks;
  int unsigned  cyc;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  function automatic int unsigned pos_of(input int unsigned k);
`ifdef FFT_OUT_BITREV_EN
    int unsigned r = 0;
    for (int i = 0; i < int'(AW); i++) begin
      if (k[i]) r = r | (32'd1 << (int'(AW) - 1 - i));
    end
    return r;
`else
    return k;
`endif
  endfunction

  function automatic logic [63:0] exp_sample(input int unsigned k);
    int unsigned p = pos_of(k);
    return 64'({(k == N - 1), AW'(k), mdl_re[p], mdl_im[p]});
  endfunction

  // One clock: advance the model with the inputs presented, then compare after the edge.
  task automatic tick();
    bit hs;
    bit rst_was;
    case (rdy_mode)
      0:       m_ready = 1'b1;
      1:       m_ready = ~m_ready;
      default: m_ready = 1'($urandom_range(0, 1));
    endcase
    hs      = drain && m_ready;
    rst_was = rst;
    if (rst) begin
      cap = 0; drain = 0; exp_k = 0; ovf_exp = 0;
    end else if (drain) begin
      if (do_en && ovf_exp < 255) ovf_exp++;
      if (hs) begin
        if (exp_k == N - 1) begin
          drain = 0;
          exp_k = 0;
        end else begin
          exp_k++;
        end
      end
    end else if (do_en) begin
      for (int unsigned l = 0; l < LANES; l++) begin
        mdl_re[cap * LANES + l] = do_re[l];
        mdl_im[cap * LANES + l] = do_im[l];
      end
      cap++;
      if (cap == BEATS) begin
        cap   = 0;
        drain = 1;
        exp_k = 0;
      end
    end
    @(posedge clk);
    #1;
    cyc++;
    chk("valid", 64'(m_valid), 64'(drain));
    chk("busy", 64'(busy), 64'(drain || cap != 0));
    chk("ovf", 64'(ovf_cnt), 64'(ovf_exp));
    if (drain) chk("sample", 64'({m_last, m_idx, m_re, m_im}), exp_sample(exp_k));
    if (rst_was) chk("rst_out", 64'({m_valid, m_last, m_idx, m_re, m_im, busy, ovf_cnt}), 64'(0));
  endtask

  task automatic load_beat(input bit ramp, input int unsigned b);
    for (int unsigned l = 0; l < LANES; l++) begin
      if (ramp) begin
        do_re[l] = W'(b * LANES + l);
        do_im[l] = W'(-int'(b * LANES + l));
      end else begin
        do_re[l] = W'($urandom);
        do_im[l] = W'($urandom);
      end
    end
  endtask

  // Sends the remaining beats of a frame, with an optional random gap probability in percent.
  task automatic send_frame(input bit ramp, input int unsigned gap);
    for (int unsigned b = cap; b < BEATS; b++) begin
      do_en = 1'b0;
      while ($urandom_range(0, 99) < gap) tick();
      load_beat(ramp, b);
      do_en = 1'b1;
      tick();
    end
    do_en = 1'b0;
  endtask

  task automatic wait_k(input int unsigned k);
    int unsigned n = 0;
    while (!(drain && exp_k == k) && n < 4000) begin
      tick();
      n++;
    end
    chk("wait_k_reached", 64'(drain && exp_k == k), 64'(1));
  endtask

  task automatic wait_idle();
    int unsigned n = 0;
    while (drain && n < 4000) begin
      tick();
      n++;
    end
    chk("drain_timeout", 64'(drain), 64'(0));
  endtask

  initial begin
    errors = 0; checks = 0; cyc = 0;
    cap = 0; exp_k = 0; drain = 0; ovf_exp = 0;
    rst = 1'b1; do_en = 1'b0; m_ready = 1'b0; rdy_mode = 0;
    do_re = '0; do_im = '0;
    tick();
    tick();
    rst = 1'b0;
    tick();

    // Ramp frame, continuous beats, always ready.
    send_frame(1'b1, 0);
    wait_k(1);
    chk("ramp_k1", 64'(m_re), 64'(RAMP_K1));
    wait_k(3);
    chk("ramp_k3", 64'(m_re), 64'(RAMP_K3));
    wait_k(511);
    chk("ramp_k511", 64'({m_last, m_re}), 64'({1'b1, W'(511)}));
    wait_idle();
    tick();

    // Gapped input with toggling backpressure.
    rdy_mode = 1;
    send_frame(1'b0, 50);
    wait_idle();

    // Second frame arriving mid-drain is dropped; a fresh frame afterwards is clean.
    rdy_mode = 0;
    send_frame(1'b0, 0);
    wait_k(100);
    for (int unsigned b = 0; b < BEATS; b++) begin
      load_beat(1'b0, b);
      do_en = 1'b1;
      tick();
    end
    do_en = 1'b0;
    chk("ovf_32", 64'(ovf_cnt), 64'(32));
    wait_idle();
    rdy_mode = 2;
    send_frame(1'b0, 20);
    wait_idle();

    // Saturation of the drop counter.
    rdy_mode = 0;
    send_frame(1'b0, 0);
    for (int i = 0; i < 300; i++) begin
      load_beat(1'b0, 0);
      do_en = 1'b1;
      tick();
    end
    do_en = 1'b0;
    chk("ovf_sat", 64'(ovf_cnt), 64'(255));
    wait_idle();

    // Reset mid-fill, then mid-drain, then a clean frame.
    rdy_mode = 2;
    for (int unsigned b = 0; b < 10; b++) begin
      load_beat(1'b0, b);
      do_en = 1'b1;
      tick();
    end
    do_en = 1'b0;
    rst = 1'b1;
    tick();
    rst = 1'b0;
    send_frame(1'b0, 0);
    wait_k(200);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    send_frame(1'b1, 10);
    wait_idle();

    // Beat coincident with the final handshake is dropped; the next beat starts a frame.
    rdy_mode = 0;
    send_frame(1'b0, 0);
    wait_k(511);
    load_beat(1'b0, 0);
    do_en = 1'b1;
    tick();
    do_en = 1'b0;
    chk("bnd_ovf", 64'(ovf_cnt), 64'(1));
    chk("bnd_idle", 64'({m_valid, busy}), 64'(0));
    load_beat(1'b0, 0);
    do_en = 1'b1;
    tick();
    do_en = 1'b0;
    chk("bnd_fill", 64'(busy), 64'(1));
    rdy_mode = 2;
    send_frame(1'b0, 30);
    wait_idle();
    tick();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/fft_out_collector.md
Name: fft_out_collector

Overview:
- Sink for the FFT core's parallel output bus (do_en / do_re / do_im, LANES samples per beat).
- Captures one complete N-point frame into a register-array buffer.
- Replays the frame as a serial valid/ready stream of one complex sample per handshake, with index and last flag.
- Sits between the FFT core and downstream consumers (UART/DMA/spectrum logic); the write side of the FFT output interface is the core, this block is the read side.

Parameters:
WIDTH, 13, signed bit width of each re/im sample (matches FFT WIDTH_OUT)
LANES, 16, samples delivered per do_en beat
N, 512, points per frame; must be a multiple of LANES and a power of two

Ports:
clk  in  1  clock, rising edge
rst  in  1  synchronous active-high reset
do_en  in  1  FFT output beat valid; no backpressure toward the FFT
do_re  in  LANES x WIDTH signed  real parts, lane 0..LANES-1
do_im  in  LANES x WIDTH signed  imaginary parts
m_valid  out  1  output sample valid
m_ready  in  1  downstream accepts sample
m_re  out  WIDTH signed  output real part
m_im  out  WIDTH signed  output imaginary part
m_idx  out  log2(N)  bin index of the current output sample
m_last  out  1  high with the sample at m_idx = N-1
busy  out  1  high in FILL or DRAIN
ovf_cnt  out  8  saturating count of beats dropped while in DRAIN

Behaviour:
- Derived constants: BEATS = N/LANES = 32; beat counter is log2(BEATS) bits; read counter is log2(N) bits.
- Storage: BEATS entries of LANES x 2 x WIDTH bits. Beat b, lane l holds stored position p = b*LANES + l.
- Reset (sync, rst=1 at clock edge): state=IDLE, counters=0, m_valid=0, m_last=0, m_idx=0, m_re=m_im=0, busy=0, ovf_cnt=0. Buffer contents are not reset.
  - Reset mid-FILL or mid-DRAIN abandons the frame; the next do_en after reset starts a new frame.
- State IDLE:
  - do_en=1 writes the beat to entry 0, wcnt=1, goes to FILL.
- State FILL:
  - Each do_en=1 writes entry wcnt and increments wcnt; gaps (do_en=0) are allowed and simply wait.
  - The write with wcnt=BEATS-1 moves to DRAIN next cycle, with rcnt=0.
- State DRAIN:
  - Output registers present sample k=rcnt. m_valid rises the first cycle in DRAIN (1 cycle after the last beat written).
  - Handshake occurs when m_valid & m_ready. On handshake rcnt increments and the output registers load sample k+1 in the same edge, so one sample per cycle is sustained with m_ready held high.
  - While m_valid=1 and m_ready=0, m_re/m_im/m_idx/m_last are held stable.
  - m_last=1 exactly when m_idx=N-1. Its handshake clears m_valid and returns to IDLE.
  - Any do_en=1 in DRAIN, including the cycle of the final handshake, is dropped and increments ovf_cnt (saturates at 255). The FFT must leave at least N cycles between frames for lossless operation.
- Output mapping: m_idx=k; m_re/m_im come from stored position p=k (natural order), or as in Optional Feature.
- Arithmetic: pass-through only, no rounding or sign change.

Optional Feature:
- Macro FFT_OUT_BITREV_EN.
- Defined: output sample k reads stored position p = bit-reverse of k over log2(N) bits (e.g. N=512: k=1 -> p=256, k=2 -> p=128). The bit-reversed FFT output is delivered in natural bin order; m_idx still counts 0..N-1.
- Undefined: p=k, no reordering; the bit-reverse logic is absent.

Decomposition:
- Shared package fft_pkg: WIDTH_OUT=13, LANES=16, N=512, derived BEATS and address widths, state enum {IDLE, FILL, DRAIN}, sample struct {re, im}.
- Sub-module fft_bitrev_addr: parameterized combinational bit-reverse of an index. It is instantiated only under FFT_OUT_BITREV_EN and is reusable by the FFT core.

Test Plan:
- Ramp frame, continuous: 32 consecutive do_en beats with lane l of beat b re=b*16+l, im=-(b*16+l), m_ready=1 -> 512 outputs m_re=k, m_im=-k for k=0..511 on consecutive cycles, m_valid first high 1 cycle after the last beat, m_last only at k=511, busy low afterward.
- Gapped input plus backpressure: beats with do_en=0 between each, m_ready toggling 1/0 -> identical 512-sample sequence, outputs stable while m_ready=0, no duplicates or skips.
- Overflow: send a second frame's beats starting at k=100 of DRAIN -> those beats dropped, ovf_cnt=number of dropped beats. A fresh frame after IDLE is captured correctly; 300 dropped beats -> ovf_cnt=255.
- Reset mid-operation: assert rst for 1 cycle at wcnt=10, then at k=200 of DRAIN -> all outputs at reset values the next cycle; the following full frame outputs correctly from k=0.
- Bitrev (FFT_OUT_BITREV_EN): ramp frame -> output k carries value bitrev9(k), e.g. k=1 -> 256, k=3 -> 384, k=511 -> 511. Without the macro, the same stimulus gives value k.
- Boundary: do_en high on the same cycle as the m_last handshake -> beat dropped, ovf_cnt=1, state IDLE; the next do_en starts FILL.
